// File: rtl/spi_reg_writer.sv
// spi_reg_writer: writes one peripheral register as an SPI mode-0 address frame followed by a data frame
module spi_reg_writer #(
   parameter int DIV = 4,
   parameter int GAP = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_addr,
   input  logic [7:0] req_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       SCLK,
   output logic       COPI,
   output logic       nCS
);
   localparam int CW = $clog2(DIV > GAP ? DIV : GAP) + 1;
   typedef enum logic [2:0] {S_IDLE, S_REJECT, S_LEAD, S_HIGH, S_LOW, S_LAG, S_GAP} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bitc;
   logic [7:0]    shreg;
   logic [7:0]    data;
   logic          byte_sel;
   logic          bad;
   logic          in_frame;
   logic          div_end;
   logic          gap_end;
   generate
      if (DIV < 4) begin : g_div_chk
         $error("spi_reg_writer: DIV must be >= 4");
      end
      if (GAP < 4) begin : g_gap_chk
         $error("spi_reg_writer: GAP must be >= 4");
      end
   endgenerate
   assign in_frame = state inside {S_LEAD, S_HIGH, S_LOW, S_LAG};
   assign div_end  = cnt == CW'(DIV - 1);
   assign gap_end  = cnt == (byte_sel ? CW'(GAP - 2) : CW'(GAP - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bitc      <= '0;
         shreg     <= '0;
         data      <= '0;
         byte_sel  <= 1'b0;
         bad       <= 1'b0;
         nCS       <= 1'b1;
         SCLK      <= 1'b0;
         COPI      <= 1'b0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         nCS       <= !in_frame;
         SCLK      <= state == S_HIGH;
         COPI      <= in_frame && shreg[7];
         busy      <= state != S_IDLE;
         req_ready <= state == S_IDLE && !(req_valid && req_ready);
         done      <= state == S_IDLE && busy && !bad;
         err       <= state == S_IDLE && busy && bad;
         cnt       <= cnt + 1'b1;
         case (state)
            S_IDLE: if (req_valid && req_ready) begin
               state    <= req_addr > 4'd4 ? S_REJECT : S_LEAD;
               bad      <= req_addr > 4'd4;
               data     <= req_data;
               shreg    <= {4'b1000, req_addr};
               byte_sel <= 1'b0;
               bitc     <= '0;
               cnt      <= '0;
            end
            S_REJECT: state <= S_IDLE;
            S_LEAD: if (div_end) begin
               state <= S_HIGH;
               cnt   <= '0;
            end
            S_HIGH: if (div_end) begin
               state <= bitc == 3'd7 ? S_LAG : S_LOW;
               shreg <= shreg << 1;
               cnt   <= '0;
            end
            S_LOW: if (div_end) begin
               state <= S_HIGH;
               bitc  <= bitc + 1'b1;
               cnt   <= '0;
            end
            S_LAG: if (div_end) begin
               state <= S_GAP;
               cnt   <= '0;
            end
            S_GAP: if (gap_end) begin
               state    <= byte_sel ? S_IDLE : S_LEAD;
               byte_sel <= 1'b1;
               shreg    <= data;
               bitc     <= '0;
               cnt      <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_reg_writer.sv
// tb_spi_reg_writer: directed bench for spi_reg_writer with a behavioural SPI register receiver
module tb_spi_reg_writer;
   localparam int DIV = 4;
   localparam int GAP = 8;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [3:0] req_addr = '0;
   logic [7:0] req_data = '0;
   logic       req_ready, busy, done, err, SCLK, COPI, nCS;
   int         checks = 0, errors = 0, cyc = 0;
   int         hs_q[$], frames[$], gaps[$], lows[$];
   int         rise_t = -1, fall_t = -1, done_t = -1, err_t = -1;
   int         done_cnt = 0, err_cnt = 0, fall_cnt = 0, viol = 0, rx_bits = 0;
   logic [7:0] rx_sh = '0;
   logic [7:0] regs [5];
   logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h80};
   logic       have_addr = 1'b0;
   logic [3:0] pa = '0;
   logic       p_sclk = 1'b0, p_copi = 1'b0, p_ncs = 1'b1;

   spi_reg_writer #(.DIV(DIV), .GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done), .err(err),
      .SCLK(SCLK), .COPI(COPI), .nCS(nCS)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         done_cnt += int'(done);
         err_cnt  += int'(err);
         if (COPI !== p_copi && p_sclk && SCLK) viol++;
         if (nCS !== p_ncs && (p_sclk || SCLK)) viol++;
      end
      p_sclk = SCLK;
      p_copi = COPI;
      p_ncs  = nCS;
   end

   always @(posedge clk) if (rst_n && req_valid && req_ready) hs_q.push_back(cyc);
   always @(posedge done) done_t = cyc;
   always @(posedge err) err_t = cyc;
   always @(posedge SCLK) if (rst_n && !nCS) begin
      rx_sh = {rx_sh[6:0], COPI};
      rx_bits++;
   end
   always @(negedge nCS) if (rst_n === 1'b1) begin
      if (rise_t >= 0) gaps.push_back(cyc - rise_t);
      fall_t = cyc;
      fall_cnt++;
      rx_bits = 0;
   end
   always @(posedge nCS) if (rst_n === 1'b1) begin
      lows.push_back(cyc - fall_t);
      frames.push_back(rx_bits * 256 + int'(rx_sh));
      rise_t = cyc;
      if (rx_bits != 8) have_addr = 1'b0;
      else if (!have_addr) begin
         have_addr = rx_sh[7];
         pa = rx_sh[3:0];
      end else begin
         if (pa < 4'd5) regs[pa] = rx_sh;
         have_addr = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] a, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      while (!req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 32'(req_ready), 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || err) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("end_timeout", 32'(n < 1000), 1);
      @(negedge clk);
   endtask

   initial begin
      int n, dc, fc, d1, min_gap;
      for (int i = 0; i < 5; i++) regs[i] = '0;
      repeat (5) begin
         @(negedge clk);
         req_valid = 1'($urandom_range(0, 1));
         req_addr  = 4'($urandom_range(0, 15));
         req_data  = 8'($urandom_range(0, 255));
      end
      chk("rst_ncs", 32'(nCS), 1);
      chk("rst_sclk", 32'(SCLK), 0);
      chk("rst_copi", 32'(COPI), 0);
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b1;

      hs_q.delete(); frames.delete(); gaps.delete(); lows.delete();
      done_cnt = 0;
      send(4'd2, 8'hA5);
      wait_end();
      chk("w1_frames", frames.size(), 2);
      chk("w1_addr_frame", frames[0], 32'h882);
      chk("w1_data_frame", frames[1], 32'h8A5);
      chk("w1_gap", gaps[0], GAP);
      chk("w1_ncs_low", lows[0], 17 * DIV);
      chk("w1_done_lat", done_t - hs_q[0], 152);
      chk("w1_done_cnt", done_cnt, 1);

      for (int i = 0; i < 5; i++) begin
         send(4'(i), vals[i]);
         wait_end();
      end
      for (int i = 0; i < 5; i++) chk($sformatf("loop_reg%0d", i), 32'(regs[i]), 32'(vals[i]));

      hs_q.delete();
      fc = fall_cnt; err_cnt = 0; done_cnt = 0; err_t = -1;
      send(4'd7, 8'h55);
      wait_end();
      chk("rej_err_lat", err_t - hs_q[0], 2);
      chk("rej_err_cnt", err_cnt, 1);
      chk("rej_ncs_idle", fall_cnt - fc, 0);
      chk("rej_no_done", done_cnt, 0);
      send(4'd1, 8'hFF);
      wait_end();
      chk("after_rej_reg1", 32'(regs[1]), 32'hFF);

      hs_q.delete(); gaps.delete();
      @(negedge clk);
      req_valid = 1'b1; req_addr = 4'd3; req_data = 8'h5A;
      n = 0;
      while (hs_q.size() < 1 && n < 500) begin @(negedge clk); n++; end
      req_addr = 4'd4; req_data = 8'hC3;
      while (hs_q.size() < 2 && n < 1000) begin @(negedge clk); n++; end
      chk("b2b_hs_timeout", 32'(n < 1000), 1);
      d1 = done_t;
      req_valid = 1'b0;
      wait_end();
      chk("b2b_hs_on_done", hs_q[1] - d1, 1);
      min_gap = 1000;
      foreach (gaps[i]) if (gaps[i] < min_gap) min_gap = gaps[i];
      chk("b2b_min_gap", 32'(min_gap >= GAP), 1);
      chk("b2b_reg3", 32'(regs[3]), 32'h5A);
      chk("b2b_reg4", 32'(regs[4]), 32'hC3);

      send(4'd2, 8'h66);
      n = 0;
      while (!(rx_bits == 4 && SCLK) && n < 500) begin @(negedge clk); n++; end
      chk("mid_reached", 32'(n < 500), 1);
      dc = done_cnt;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_ncs", 32'(nCS), 1);
      chk("mid_sclk", 32'(SCLK), 0);
      chk("mid_ready", 32'(req_ready), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      have_addr = 1'b0;
      rise_t = -1;
      repeat (200) @(negedge clk);
      chk("mid_no_done", done_cnt - dc, 0);
      frames.delete();
      send(4'd3, 8'h3C);
      wait_end();
      chk("post_rst_addr", frames[0], 32'h883);
      chk("post_rst_data", frames[1], 32'h83C);
      chk("post_rst_reg3", 32'(regs[3]), 32'h3C);
      chk("spi_protocol", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
